// File: rtl/spreading_factors_pkg.sv
// Shared constants and types for the DCSK receive correlator.
// Spreading-factor codes select 4/8/16/32 chips per half-bit.
package spreading_factors_pkg;

  localparam logic [1:0] SF4  = 2'd0;
  localparam logic [1:0] SF8  = 2'd1;
  localparam logic [1:0] SF16 = 2'd2;
  localparam logic [1:0] SF32 = 2'd3;

  localparam int unsigned CHIP_W         = 8;
  localparam int unsigned CORR_W         = 21;
  localparam int unsigned BITS_PER_FRAME = 32;
  localparam int unsigned MAX_SF         = 32;
  localparam int unsigned IDX_W          = 5;
  localparam int unsigned PROD_W         = 2 * CHIP_W;

  typedef enum logic {
    S_REF  = 1'b0,
    S_DATA = 1'b1
  } rx_state_e;

  // Index of the last chip in a half-bit for a given spreading factor.
  function automatic logic [IDX_W-1:0] sf_last_idx(input logic [1:0] sf);
    logic [IDX_W-1:0] last;
    case (sf)
      SF4:     last = 5'd3;
      SF8:     last = 5'd7;
      SF16:    last = 5'd15;
      default: last = 5'd31;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/dcsk_ref_buf.sv
// Reference chip store: 32 x 8-bit, synchronous write, combinational read.
// Contents are not reset; every slot is written before it is read.
module dcsk_ref_buf
  import spreading_factors_pkg::*;
(
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         addr,
  input  logic signed [CHIP_W-1:0] wdata,
  output logic signed [CHIP_W-1:0] rdata
);

  logic signed [CHIP_W-1:0] mem [MAX_SF];

  // Capture reference chips as they arrive.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dcsk_rx_correlator.sv
// DCSK receive correlator: buffers SF reference chips, correlates the next SF
// data chips against them, and issues a hard decision one cycle after the last
// data chip. Frames are 32 bits; the spreading factor is sampled at frame start.
// Optional soft output o_corr is enabled by defining DCSK_RX_SOFT_OUT_EN.
module dcsk_rx_correlator
  import spreading_factors_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [1:0]               i_sf,
  input  logic                     i_chip_valid,
  input  logic signed [CHIP_W-1:0] i_chip,
  output logic                     o_bit_valid,
  output logic                     o_bit,
  output logic [IDX_W-1:0]         o_bit_index,
  output logic                     o_frame_done
`ifdef DCSK_RX_SOFT_OUT_EN
  ,
  output logic signed [CORR_W-1:0] o_corr
`endif
);

  rx_state_e                state;
  logic [IDX_W-1:0]         chip_idx;
  logic signed [CORR_W-1:0] acc;
  logic [1:0]               sf_lat;

  logic [IDX_W-1:0]         last_idx;
  logic [IDX_W-1:0]         next_bit_idx;
  logic                     sf_latch_en;
  logic                     ref_we;
  logic signed [CHIP_W-1:0] ref_chip;
  logic signed [PROD_W-1:0] prod;
  logic signed [CORR_W-1:0] prod_ext;
  logic signed [CORR_W-1:0] acc_next;
  logic                     last_chip;
  logic                     dec_fire;

  assign last_idx  = sf_last_idx(sf_lat);
  assign last_chip = (chip_idx == last_idx);

  // Index of the bit about to start; looks past a pending pulse so the frame
  // boundary is seen even when the next chip arrives in the pulse cycle.
  assign next_bit_idx = o_bit_valid ? o_bit_index + 5'd1 : o_bit_index;
  assign sf_latch_en  = (state == S_REF) && (chip_idx == '0) && (next_bit_idx == '0);

  assign ref_we = i_chip_valid && (state == S_REF);

  dcsk_ref_buf u_ref_buf (
    .clk   (i_clk),
    .we    (ref_we),
    .addr  (chip_idx),
    .wdata (i_chip),
    .rdata (ref_chip)
  );

  assign prod     = PROD_W'(i_chip) * PROD_W'(ref_chip);
  assign prod_ext = {{(CORR_W - PROD_W){prod[PROD_W-1]}}, prod};
  // First data chip loads the accumulator, later ones add to it.
  assign acc_next = (chip_idx == '0) ? prod_ext : acc + prod_ext;
  assign dec_fire = i_chip_valid && (state == S_DATA) && last_chip;

  // Spreading factor is sampled only at the start of a frame.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sf_lat <= SF4;
    end else if (sf_latch_en) begin
      sf_lat <= i_sf;
    end
  end

  // Reference/data sequencing, chip counter and correlation accumulator.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= S_REF;
      chip_idx <= '0;
      acc      <= '0;
    end else if (i_chip_valid) begin
      case (state)
        S_REF: begin
          if (last_chip) begin
            state    <= S_DATA;
            chip_idx <= '0;
          end else begin
            chip_idx <= chip_idx + 5'd1;
          end
        end
        S_DATA: begin
          acc <= acc_next;
          if (last_chip) begin
            state    <= S_REF;
            chip_idx <= '0;
          end else begin
            chip_idx <= chip_idx + 5'd1;
          end
        end
        default: begin
          state    <= S_REF;
          chip_idx <= '0;
        end
      endcase
    end
  end

  // Registered decision outputs and frame bit counter.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_bit_valid  <= 1'b0;
      o_bit        <= 1'b0;
      o_frame_done <= 1'b0;
      o_bit_index  <= '0;
    end else begin
      o_bit_valid  <= dec_fire;
      o_frame_done <= dec_fire && (o_bit_index == IDX_W'(BITS_PER_FRAME - 1));
      if (dec_fire) begin
        o_bit <= ~acc_next[CORR_W-1];
      end
      // Advance after the decision has been presented.
      if (o_bit_valid) begin
        o_bit_index <= o_bit_index + 5'd1;
      end
    end
  end

`ifdef DCSK_RX_SOFT_OUT_EN
  // Soft value of the last decision, held until the next one.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_corr <= '0;
    end else if (dec_fire) begin
      o_corr <= acc_next;
    end
  end
`endif

endmodule

// File: tb/tb_dcsk_rx_correlator.sv
// Directed self-checking bench for dcsk_rx_correlator.
// Soft-output checks are active only when DCSK_RX_SOFT_OUT_EN is defined.
module tb_dcsk_rx_correlator;
  import spreading_factors_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_arst_n = 1'b0;
  logic [1:0]        i_sf = SF4;
  logic              i_chip_valid = 1'b0;
  logic signed [7:0] i_chip = '0;
  logic              o_bit_valid;
  logic              o_bit;
  logic [4:0]        o_bit_index;
  logic              o_frame_done;
`ifdef DCSK_RX_SOFT_OUT_EN
  logic signed [20:0] o_corr;
`endif

  int total = 0;
  int bad = 0;

  dcsk_rx_correlator dut (
    .i_clk        (i_clk),
    .i_arst_n     (i_arst_n),
    .i_sf         (i_sf),
    .i_chip_valid (i_chip_valid),
    .i_chip       (i_chip),
    .o_bit_valid  (o_bit_valid),
    .o_bit        (o_bit),
    .o_bit_index  (o_bit_index),
    .o_frame_done (o_frame_done)
`ifdef DCSK_RX_SOFT_OUT_EN
    ,
    .o_corr       (o_corr)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Pulse recorder, sampled on the falling edge.
  logic [4:0] mon_idx [64];
  logic       mon_bit [64];
  logic       mon_fd  [64];
  int         mon_cnt = 0;
  int         fd_stray = 0;

  always @(negedge i_clk) begin
    if (o_frame_done && !o_bit_valid) fd_stray = fd_stray + 1;
    if (o_bit_valid) begin
      if (mon_cnt < 64) begin
        mon_idx[mon_cnt] = o_bit_index;
        mon_bit[mon_cnt] = o_bit;
        mon_fd[mon_cnt]  = o_frame_done;
      end
      mon_cnt = mon_cnt + 1;
    end
  end

  logic signed [7:0] r8 [8];
  logic signed [7:0] d8 [8];

  task automatic chip(input logic signed [7:0] c);
    i_chip_valid = 1'b1;
    i_chip = c;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_chip_valid = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] sf);
    i_chip_valid = 1'b0;
    i_sf = sf;
    i_arst_n = 1'b0;
    #3;
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    idle(1);
  endtask

  task automatic load_sf8_vec();
    r8 = '{8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50, -8'sd60, 8'sd70, -8'sd80};
    d8 = '{-8'sd3, 8'sd5, 8'sd2, -8'sd1, 8'sd4, 8'sd0, -8'sd6, 8'sd7};
  endtask

  task automatic test_reset();
    #3;
    total++; if (o_bit_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0d want 0", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL rst_bit: got %0d want 0", o_bit); end
    total++; if (o_bit_index !== 5'd0) begin bad++; $display("FAIL rst_index: got %0d want 0", o_bit_index); end
    total++; if (o_frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %0d want 0", o_frame_done); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (o_corr !== 21'sd0) begin bad++; $display("FAIL rst_corr: got %0d want 0", o_corr); end
`endif
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    idle(2);
    total++; if (o_bit_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid: got %0d want 0", o_bit_valid); end
  endtask

  task automatic test_sf4_match();
    logic signed [7:0] r [4];
    r = '{8'sd100, -8'sd50, 8'sd20, -8'sd7};
    do_reset(SF4);
    for (int i = 0; i < 4; i++) chip(r[i]);
    for (int i = 0; i < 3; i++) chip(r[i]);
    total++; if (o_bit_valid !== 1'b0) begin bad++; $display("FAIL sf4_early: got %0d want 0", o_bit_valid); end
    chip(r[3]);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL sf4_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b1) begin bad++; $display("FAIL sf4_bit: got %0d want 1", o_bit); end
    total++; if (o_bit_index !== 5'd0) begin bad++; $display("FAIL sf4_index: got %0d want 0", o_bit_index); end
    total++; if (o_frame_done !== 1'b0) begin bad++; $display("FAIL sf4_fd: got %0d want 0", o_frame_done); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== 12949) begin bad++; $display("FAIL sf4_corr: got %0d want 12949", o_corr); end
`endif
    idle(1);
    total++; if (o_bit_valid !== 1'b0) begin bad++; $display("FAIL sf4_one_cycle: got %0d want 0", o_bit_valid); end
    total++; if (o_bit_index !== 5'd1) begin bad++; $display("FAIL sf4_index_inc: got %0d want 1", o_bit_index); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== 12949) begin bad++; $display("FAIL sf4_corr_hold: got %0d want 12949", o_corr); end
`endif
  endtask

  task automatic test_sf32_anti();
    do_reset(SF32);
    for (int i = 0; i < 32; i++) chip(8'sh80);
    for (int i = 0; i < 31; i++) chip(8'sd127);
    total++; if (o_bit_valid !== 1'b0) begin bad++; $display("FAIL sf32_early: got %0d want 0", o_bit_valid); end
    chip(8'sd127);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL sf32_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL sf32_bit: got %0d want 0", o_bit); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== -520192) begin bad++; $display("FAIL sf32_corr: got %0d want -520192", o_corr); end
`endif
    idle(1);
  endtask

  task automatic test_sf8_gaps();
    int snap;
    load_sf8_vec();
    do_reset(SF8);
    for (int i = 0; i < 8; i++) chip(r8[i]);
    for (int i = 0; i < 8; i++) chip(d8[i]);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL sf8_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL sf8_bit: got %0d want 0", o_bit); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== -810) begin bad++; $display("FAIL sf8_corr: got %0d want -810", o_corr); end
`endif
    do_reset(SF8);
    snap = mon_cnt;
    for (int i = 0; i < 16; i++) begin
      chip(i < 8 ? r8[i] : d8[i-8]);
      if (i < 15) begin
        i_chip_valid = 1'b0;
        i_chip = 8'sd127;
        @(posedge i_clk);
        #1;
      end
      if (i == 14) begin
        total++; if (mon_cnt !== snap) begin bad++; $display("FAIL gap_early: got %0d want %0d", mon_cnt, snap); end
      end
    end
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL gap_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL gap_bit: got %0d want 0", o_bit); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== -810) begin bad++; $display("FAIL gap_corr: got %0d want -810", o_corr); end
`endif
    idle(1);
  endtask

  task automatic test_frame();
    int  start;
    logic e;
    do_reset(SF16);
    start = mon_cnt;
    for (int b = 0; b < 32; b++) begin
      if (b == 10) i_sf = SF4;
      for (int i = 0; i < 16; i++) chip(8'sd3);
      for (int i = 0; i < 16; i++) chip((b % 3 != 0) ? 8'sd2 : -8'sd2);
    end
    // Next frame runs at SF4 straight after bit 31 with no gap.
    for (int i = 0; i < 4; i++) chip(8'sd4);
    for (int i = 0; i < 4; i++) chip(-8'sd1);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL frame_sf4_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit_index !== 5'd0) begin bad++; $display("FAIL frame_sf4_index: got %0d want 0", o_bit_index); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL frame_sf4_bit: got %0d want 0", o_bit); end
    idle(2);
    total++; if (mon_cnt - start !== 33) begin bad++; $display("FAIL frame_pulses: got %0d want 33", mon_cnt - start); end
    total++; if (fd_stray !== 0) begin bad++; $display("FAIL frame_fd_stray: got %0d want 0", fd_stray); end
    for (int b = 0; b < 33; b++) begin
      e = (b == 32) ? 1'b0 : (b % 3 != 0);
      total++; if (mon_idx[start+b] !== 5'(b % 32)) begin bad++; $display("FAIL frame_idx[%0d]: got %0d want %0d", b, mon_idx[start+b], b % 32); end
      total++; if (mon_bit[start+b] !== e) begin bad++; $display("FAIL frame_bit[%0d]: got %0d want %0d", b, mon_bit[start+b], e); end
      total++; if (mon_fd[start+b] !== (b == 31)) begin bad++; $display("FAIL frame_fd[%0d]: got %0d want %0d", b, mon_fd[start+b], b == 31); end
    end
  endtask

  task automatic test_reset_mid_bit();
    int snap;
    load_sf8_vec();
    do_reset(SF8);
    for (int i = 0; i < 8; i++) chip(r8[i]);
    for (int i = 0; i < 8; i++) chip(d8[i]);
    for (int i = 0; i < 8; i++) chip(8'sd50);
    for (int i = 0; i < 5; i++) chip(8'sd50);
    i_chip_valid = 1'b0;
    i_arst_n = 1'b0;
    #2;
    total++; if (o_bit_index !== 5'd0) begin bad++; $display("FAIL mid_rst_index: got %0d want 0", o_bit_index); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (o_corr !== 21'sd0) begin bad++; $display("FAIL mid_rst_corr: got %0d want 0", o_corr); end
`endif
    snap = mon_cnt;
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    idle(40);
    total++; if (mon_cnt !== snap) begin bad++; $display("FAIL mid_rst_no_pulse: got %0d want %0d", mon_cnt, snap); end
    for (int i = 0; i < 8; i++) chip(r8[i]);
    for (int i = 0; i < 8; i++) chip(d8[i]);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL mid_rst_bit: got %0d want 0", o_bit); end
    total++; if (o_bit_index !== 5'd0) begin bad++; $display("FAIL mid_rst_idx: got %0d want 0", o_bit_index); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== -810) begin bad++; $display("FAIL mid_rst_corr2: got %0d want -810", o_corr); end
`endif
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] s [16];
    s = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd1, -8'sd1,
          8'sd5, -8'sd3, 8'sd7, 8'sd2, -8'sd5, 8'sd3, -8'sd7, -8'sd2};
    do_reset(SF4);
    for (int i = 0; i < 8; i++) chip(s[i]);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL zero_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b1) begin bad++; $display("FAIL zero_bit: got %0d want 1", o_bit); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (o_corr !== 21'sd0) begin bad++; $display("FAIL zero_corr: got %0d want 0", o_corr); end
`endif
    for (int i = 8; i < 16; i++) chip(s[i]);
    total++; if (o_bit_valid !== 1'b1) begin bad++; $display("FAIL neg_valid: got %0d want 1", o_bit_valid); end
    total++; if (o_bit !== 1'b0) begin bad++; $display("FAIL neg_bit: got %0d want 0", o_bit); end
    total++; if (o_bit_index !== 5'd1) begin bad++; $display("FAIL neg_index: got %0d want 1", o_bit_index); end
`ifdef DCSK_RX_SOFT_OUT_EN
    total++; if (int'(o_corr) !== -87) begin bad++; $display("FAIL neg_corr: got %0d want -87", o_corr); end
`endif
    idle(1);
  endtask

  initial begin
    test_reset();
    test_sf4_match();
    test_sf32_anti();
    test_sf8_gaps();
    test_frame();
    test_reset_mid_bit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
